// File: rtl/cpu_pkg.sv
// Shared definitions for the core's interrupt entry/exit sequencing:
// sequencer state encoding, CCR bit positions and instruction-memory source codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_PUSH    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_SERVICE = 3'd4,
        ST_RESTORE = 3'd5
    } seq_state_e;

    // CCR bit positions within {V,C,N,Z}
    localparam int CCR_V = 3;
    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    // inst_mem_src code the branch unit selects when Interrupt is pulsed
    localparam logic [1:0] INST_MEM_SRC_INT_VEC = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; a level held high yields a single one-cycle rise_pulse.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // shift the raw input through the chain, then remember the last synchronised value
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer for the 8-bit pipelined core.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no interrupt activity; waits for a pending request
//   DRAIN   | fetch stalled while in-flight instructions retire
//   PUSH    | MEM stage writes PC to the stack; CCR captured into shadow
//   VECTOR  | Interrupt pulse redirects fetch to the M[1] vector
//   SERVICE | ISR running; further requests are held, not nested
//   RESTORE | RTI seen; CCR reloads from the shadow copy
module interrupt_sequencer
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       INTR,
    input  logic       Branch_taken,
    input  logic       Mem_busy,
    input  logic       RTI_exec,
    input  logic [3:0] CCR_in,
    output logic       Stall_fetch,
    output logic       Push_PC,
    output logic       Interrupt,
    output logic [3:0] Flags_shadow,
    output logic       Flags_restore,
    output logic       In_service
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q;
    logic             intr_rise;
    logic             enter_push;
    logic [3:0]       shadow_q;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .async_in   (INTR),
        .rise_pulse (intr_rise)
    );

    // state, drain counter, pending request and flag shadow registers
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // a new edge wins over the clear so a request arriving at PUSH entry is kept
            if (intr_rise)
                pending_q <= 1'b1;
            else if (enter_push)
                pending_q <= 1'b0;
            if (state_q == ST_PUSH) begin
                shadow_q[CCR_V] <= CCR_in[CCR_V];
                shadow_q[CCR_C] <= CCR_in[CCR_C];
                shadow_q[CCR_N] <= CCR_in[CCR_N];
                shadow_q[CCR_Z] <= CCR_in[CCR_Z];
            end
        end
    end

    // next-state, drain counter and state-decoded outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        Stall_fetch   = 1'b0;
        Push_PC       = 1'b0;
        Interrupt     = 1'b0;
        Flags_restore = 1'b0;
        In_service    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_RELOAD;
                end
            end
            ST_DRAIN: begin
                Stall_fetch = 1'b1;
                // a redirect refills the pipe, so the drain window starts over
                if (Branch_taken)
                    cnt_d = DRAIN_RELOAD;
                else if (cnt_q == '0) begin
                    if (!Mem_busy)
                        state_d = ST_PUSH;
                end else
                    cnt_d = cnt_q - 1'b1;
            end
            ST_PUSH: begin
                Stall_fetch = 1'b1;
                Push_PC     = 1'b1;
                state_d     = ST_VECTOR;
            end
            ST_VECTOR: begin
                Stall_fetch = 1'b1;
                Interrupt   = 1'b1;
                state_d     = ST_SERVICE;
            end
            ST_SERVICE: begin
                In_service = 1'b1;
                if (RTI_exec)
                    state_d = ST_RESTORE;
            end
            ST_RESTORE: begin
                In_service    = 1'b1;
                Flags_restore = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_push   = (state_q == ST_DRAIN) && (state_d == ST_PUSH);
    assign Flags_shadow = shadow_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer. Each interrupt episode is
// described by a few numbers (drain start, branch restart offset, memory wait,
// ISR length); the expected timeline of every output is derived from them.
module tb_interrupt_sequencer;

    localparam int SYNC = 2;
    localparam int DC   = 3;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic       INTR;
    logic       Branch_taken;
    logic       Mem_busy;
    logic       RTI_exec;
    logic [3:0] CCR_in;
    logic       Stall_fetch;
    logic       Push_PC;
    logic       Interrupt;
    logic [3:0] Flags_shadow;
    logic       Flags_restore;
    logic       In_service;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] shadow_model = 4'b0000;

    interrupt_sequencer #(
        .SYNC_STAGES  (SYNC),
        .DRAIN_CYCLES (DC)
    ) dut (
        .CLK           (CLK),
        .Reset_n       (Reset_n),
        .INTR          (INTR),
        .Branch_taken  (Branch_taken),
        .Mem_busy      (Mem_busy),
        .RTI_exec      (RTI_exec),
        .CCR_in        (CCR_in),
        .Stall_fetch   (Stall_fetch),
        .Push_PC       (Push_PC),
        .Interrupt     (Interrupt),
        .Flags_shadow  (Flags_shadow),
        .Flags_restore (Flags_restore),
        .In_service    (In_service)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench did not complete");
    end

    task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all(input int c, input bit es, input bit ep, input bit ei,
                           input bit er, input bit esv);
        chk("stall_fetch",   c, {3'b0, Stall_fetch},   {3'b0, es});
        chk("push_pc",       c, {3'b0, Push_PC},       {3'b0, ep});
        chk("interrupt",     c, {3'b0, Interrupt},     {3'b0, ei});
        chk("flags_restore", c, {3'b0, Flags_restore}, {3'b0, er});
        chk("in_service",    c, {3'b0, In_service},    {3'b0, esv});
        chk("flags_shadow",  c, Flags_shadow,          shadow_model);
    endtask

    // One interrupt episode. Cycle 0 is the cycle INTR rises (d0=4) or the
    // first DRAIN cycle of an already-queued request (d0=0).
    //   k  : DRAIN cycle index carrying Branch_taken (-1 = none)
    //   m  : Mem_busy cycles once the drain window has elapsed
    //   ls : ISR length in cycles, RTI on its last cycle
    //   second : raise a new INTR edge on the first ISR cycle (queued request)
    task automatic run_entry(input int d0, input int k, input int m, input int hold,
                             input int ls, input bit second, input bit fixed_ccr,
                             input logic [3:0] ccr);
        int d, z, p, v, s, r, last;
        logic [3:0] cap;
        d    = d0;
        z    = (k < 0) ? d + DC - 1 : d + k + DC;
        p    = z + m + 1;
        v    = p + 1;
        s    = v + 1;
        r    = s + ls - 1;
        last = second ? r + 2 : r + 6;
        cap  = 4'b0000;
        for (int c = 0; c <= last; c++) begin
            INTR         = ((d0 != 0) && (c < hold)) || (second && (c >= s));
            Branch_taken = ((k >= 0) && (c == d + k)) ||
                           (((c < d) || (c > p)) && ($urandom_range(0, 3) == 0));
            Mem_busy     = ((c >= z) && (c < z + m)) ||
                           (((c < d) || (c > p)) && ($urandom_range(0, 1) == 1));
            RTI_exec     = (c == r) || (c == d) ||
                           (((c < d) || (c > r + 1)) && ($urandom_range(0, 3) == 0));
            CCR_in       = fixed_ccr ? ccr : 4'($urandom);
            if (c == p) cap = CCR_in;
            @(negedge CLK);
            if (c == v) shadow_model = cap;
            chk_all(c, (c >= d) && (c <= v), c == p, c == v, c == r + 1,
                    (c >= s) && (c <= r + 1));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int k, m, ls, hold;
        bit second, queued;

        Reset_n      = 1'b0;
        INTR         = 1'b0;
        Branch_taken = 1'b0;
        Mem_busy     = 1'b0;
        RTI_exec     = 1'b0;
        CCR_in       = 4'b0000;

        // reset state
        #23;
        chk_all(-1, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        @(posedge CLK);
        #1;

        // stray RTI while idle
        for (int c = 0; c < 4; c++) begin
            RTI_exec = 1'b1;
            CCR_in   = 4'($urandom);
            @(negedge CLK);
            chk_all(c, 0, 0, 0, 0, 0);
            @(posedge CLK);
            #1;
        end
        RTI_exec = 1'b0;

        // basic entry, INTR held 20 cycles, long ISR: exactly one entry
        run_entry(4, -1, 0, 20, 16, 1'b0, 1'b1, 4'b0101);

        // branch restart on the second DRAIN cycle, then a queued request from the ISR
        run_entry(4, 1, 0, 2, 4, 1'b1, 1'b1, 4'b0101);

        // queued request entering DRAIN straight after IDLE, memory busy 4 cycles
        run_entry(0, -1, 4, 0, 3, 1'b0, 1'b1, 4'b0101);

        // asynchronous reset in the middle of DRAIN
        for (int c = 0; c <= 5; c++) begin
            INTR         = (c < 2);
            Branch_taken = 1'b0;
            Mem_busy     = 1'b0;
            RTI_exec     = 1'b0;
            @(negedge CLK);
            chk_all(c, c >= 4, 0, 0, 0, 0);
            if (c < 5) begin
                @(posedge CLK);
                #1;
            end
        end
        #2;
        Reset_n      = 1'b0;
        shadow_model = 4'b0000;
        #1;
        chk_all(100, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            Branch_taken = ($urandom_range(0, 1) == 1);
            Mem_busy     = ($urandom_range(0, 1) == 1);
            RTI_exec     = ($urandom_range(0, 1) == 1);
            CCR_in       = 4'($urandom);
            @(negedge CLK);
            chk_all(200 + c, 0, 0, 0, 0, 0);
            @(posedge CLK);
            #1;
        end

        // randomised episodes
        queued = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k      = int'($urandom_range(0, DC)) - 1;
            m      = int'($urandom_range(0, 4));
            ls     = int'($urandom_range(3, 8));
            hold   = int'($urandom_range(1, 3));
            second = ($urandom_range(0, 1) == 1);
            run_entry(queued ? 0 : 4, k, m, hold, ls, second, 1'b0, 4'b0000);
            queued = second;
        end
        if (queued)
            run_entry(0, -1, 0, 0, 3, 1'b0, 1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
